// File: rtl/busca_instrucao_pkg.sv
// Shared types and constants for the Redux-V instruction-fetch stage.
//   estado_t       : fetch FSM states
//   LARGURA_PADRAO : default address/data/PC width
package pacote_busca;

    localparam int unsigned LARGURA_PADRAO = 8;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2,
        ERRO    = 2'd3
    } estado_t;

endpackage

// File: rtl/busca_instrucao_contador_timeout.sv
// Saturating wait counter for the fetch timeout.
//   clk, rst_n : clock and async active-low reset
//   limpa      : clear the count (wins over conta)
//   conta      : advance the count by one, saturating at LIMITE-1
//   estourou   : the current cycle is the LIMITE-th counted cycle
module contador_timeout #(
    parameter int unsigned LIMITE = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic limpa,
    input  logic conta,
    output logic estourou
);

    localparam int unsigned W = $clog2(LIMITE + 1);
    localparam logic [W-1:0] MAXIMO = W'(LIMITE - 1);

    logic [W-1:0] contagem;

    // Count cycles spent waiting; hold at MAXIMO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (conta && contagem != MAXIMO) begin
            contagem <= contagem + W'(1);
        end
    end

    assign estourou = conta && !limpa && (contagem == MAXIMO);

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: reads one byte at pc, holds it in an instruction
// register for the decoder (valid/ready) and computes the next PC.
//   pc / proximo_pc       : PC in / next PC out (proximo_pc is combinational)
//   mem_req, mem_end      : single-beat read request and address
//   mem_dado, mem_pronto  : read data and completion strobe
//   desvio, alvo          : taken branch / flush and its target
//   instr, pc_instr       : fetched instruction and its address
//   instr_valida, dec_pronto : handshake with the decoder
//   erro                  : sticky fetch timeout
// Optional feature macro: BUSCA_TIMEOUT_EN (fetch timeout into ERRO state).
module busca_instrucao
    import pacote_busca::*;
#(
    parameter int unsigned LARGURA        = LARGURA_PADRAO,
    parameter int unsigned TIMEOUT_CICLOS = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] pc,
    output logic [LARGURA-1:0] proximo_pc,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_end,
    input  logic [LARGURA-1:0] mem_dado,
    input  logic               mem_pronto,
    input  logic               desvio,
    input  logic [LARGURA-1:0] alvo,
    output logic [LARGURA-1:0] instr,
    output logic [LARGURA-1:0] pc_instr,
    output logic               instr_valida,
    input  logic               dec_pronto,
    output logic               erro
);

    estado_t estado;
    logic    estourou;
    logic    flush;

    // A branch flushes the stage from any state but ERRO
    assign flush = desvio && (estado != ERRO);

`ifdef BUSCA_TIMEOUT_EN
    contador_timeout #(
        .LIMITE (TIMEOUT_CICLOS)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .limpa    ((estado != BUSCA) || mem_pronto),
        .conta    (estado == BUSCA),
        .estourou (estourou)
    );

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            erro <= 1'b0;
        end else if (estado == BUSCA && !flush && !mem_pronto && estourou) begin
            erro <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CICLOS == 0);
    assign estourou       = 1'b0;
    assign erro           = 1'b0;
`endif

    // Next PC: branch target, increment on completed fetch, else hold
    always_comb begin
        proximo_pc = pc;
        if (!rst_n) begin
            proximo_pc = pc;
        end else if (flush) begin
            proximo_pc = alvo;
        end else if (estado == BUSCA && mem_pronto) begin
            proximo_pc = pc + LARGURA'(1);
        end
    end

    // Fetch FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= OCIOSO;
            mem_req      <= 1'b0;
            mem_end      <= '0;
            instr        <= '0;
            pc_instr     <= '0;
            instr_valida <= 1'b0;
        end else if (flush) begin
            estado       <= OCIOSO;
            mem_req      <= 1'b0;
            instr_valida <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    estado  <= BUSCA;
                    mem_end <= pc;
                    mem_req <= 1'b1;
                end
                BUSCA: begin
                    if (mem_pronto) begin
                        estado       <= ENTREGA;
                        instr        <= mem_dado;
                        pc_instr     <= mem_end;
                        instr_valida <= 1'b1;
                        mem_req      <= 1'b0;
                    end else if (estourou) begin
                        estado  <= ERRO;
                        mem_req <= 1'b0;
                    end
                end
                ENTREGA: begin
                    if (dec_pronto) begin
                        estado       <= BUSCA;
                        instr_valida <= 1'b0;
                        mem_end      <= pc;
                        mem_req      <= 1'b1;
                    end
                end
                default: begin
                    estado <= ERRO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed self-checking bench for busca_instrucao. A bench-side PC register
// stands in for contador_de_programa (loads pc_ini on reset, else proximo_pc).
module tb_busca_instrucao;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pc;
    logic [7:0] pc_ini;
    logic [7:0] proximo_pc;
    logic       mem_req;
    logic [7:0] mem_end;
    logic [7:0] mem_dado;
    logic       mem_pronto;
    logic       desvio;
    logic [7:0] alvo;
    logic [7:0] instr;
    logic [7:0] pc_instr;
    logic       instr_valida;
    logic       dec_pronto;
    logic       erro;

    int errors = 0;
    int checks = 0;

    busca_instrucao dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .proximo_pc   (proximo_pc),
        .mem_req      (mem_req),
        .mem_end      (mem_end),
        .mem_dado     (mem_dado),
        .mem_pronto   (mem_pronto),
        .desvio       (desvio),
        .alvo         (alvo),
        .instr        (instr),
        .pc_instr     (pc_instr),
        .instr_valida (instr_valida),
        .dec_pronto   (dec_pronto),
        .erro         (erro)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= pc_ini;
        else        pc <= proximo_pc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; pc_ini = 8'd10; mem_dado = 8'h00; mem_pronto = 1'b0;
        desvio = 1'b0; alvo = 8'h00; dec_pronto = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_end", 32'(mem_end), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_pc_instr", 32'(pc_instr), 32'd0);
        check("rst_valida", 32'(instr_valida), 32'd0);
        check("rst_erro", 32'(erro), 32'd0);
        check("rst_proximo_pc", 32'(proximo_pc), 32'd10);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait fetch at pc=10
        tick();
        check("t1_mem_req", 32'(mem_req), 32'd1);
        check("t1_mem_end", 32'(mem_end), 32'd10);
        mem_pronto = 1'b1; mem_dado = 8'hA5;
        #1 check("t1_proximo_pc", 32'(proximo_pc), 32'd11);
        tick();
        mem_pronto = 1'b0;
        check("t1_instr", 32'(instr), 32'hA5);
        check("t1_pc_instr", 32'(pc_instr), 32'd10);
        check("t1_valida", 32'(instr_valida), 32'd1);
        check("t1_req_low", 32'(mem_req), 32'd0);
        #1 check("t1_entrega_pc", 32'(proximo_pc), 32'd11);
        tick();
        check("t1_next_req", 32'(mem_req), 32'd1);
        check("t1_next_end", 32'(mem_end), 32'd11);
        check("t1_valida_low", 32'(instr_valida), 32'd0);

        // Fetch at 11 completes immediately, moving pc to 12
        mem_pronto = 1'b1; mem_dado = 8'h3C;
        tick();
        mem_pronto = 1'b0;
        check("t2_instr11", 32'(instr), 32'h3C);
        tick();
        check("t2_end12", 32'(mem_end), 32'd12);

        // Three wait states at pc=12
        for (int i = 0; i < 3; i++) begin
            #1 check("t2_wait_pc", 32'(proximo_pc), 32'd12);
            tick();
            check("t2_wait_req", 32'(mem_req), 32'd1);
            check("t2_wait_end", 32'(mem_end), 32'd12);
        end
        mem_pronto = 1'b1; mem_dado = 8'h5A;
        #1 check("t2_done_pc", 32'(proximo_pc), 32'd13);
        tick();
        mem_pronto = 1'b0;
        check("t2_instr", 32'(instr), 32'h5A);
        check("t2_pc_instr", 32'(pc_instr), 32'd12);

        // Decoder stalls for 5 cycles
        dec_pronto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("t3_stall_pc", 32'(proximo_pc), 32'd13);
            tick();
            check("t3_instr", 32'(instr), 32'h5A);
            check("t3_pc_instr", 32'(pc_instr), 32'd12);
            check("t3_valida", 32'(instr_valida), 32'd1);
            check("t3_no_req", 32'(mem_req), 32'd0);
        end
        dec_pronto = 1'b1;
        tick();
        check("t3_resume_req", 32'(mem_req), 32'd1);
        check("t3_resume_end", 32'(mem_end), 32'd13);

        // Branch in the same cycle as mem_pronto: data discarded
        mem_pronto = 1'b1; mem_dado = 8'hEE; desvio = 1'b1; alvo = 8'd19;
        #1 check("t4_proximo_pc", 32'(proximo_pc), 32'd19);
        tick();
        mem_pronto = 1'b0; desvio = 1'b0;
        check("t4_valida", 32'(instr_valida), 32'd0);
        check("t4_req", 32'(mem_req), 32'd0);
        check("t4_instr_kept", 32'(instr), 32'h5A);
        check("t4_pc", 32'(pc), 32'd19);
        tick();
        check("t4_req2", 32'(mem_req), 32'd1);
        check("t4_end2", 32'(mem_end), 32'd19);

        // Reset mid-BUSCA aborts the request at once
        pc_ini = 8'd255;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_req", 32'(mem_req), 32'd0);
        check("t5_rst_end", 32'(mem_end), 32'd0);
        check("t5_rst_instr", 32'(instr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // PC wrap 255 -> 0
        tick();
        check("t5_end255", 32'(mem_end), 32'd255);
        mem_pronto = 1'b1; mem_dado = 8'h77;
        #1 check("t5_wrap", 32'(proximo_pc), 32'd0);
        tick();
        mem_pronto = 1'b0;
        check("t5_instr", 32'(instr), 32'h77);
        check("t5_pc_instr", 32'(pc_instr), 32'd255);
        tick();
        check("t5_end0", 32'(mem_end), 32'd0);
        check("t5_req", 32'(mem_req), 32'd1);

`ifdef BUSCA_TIMEOUT_EN
        // No answer: erro after 15 cycles in BUSCA, sticky through desvio
        for (int i = 0; i < 14; i++) begin
            tick();
            check("t6_erro_low", 32'(erro), 32'd0);
        end
        tick();
        check("t6_erro", 32'(erro), 32'd1);
        check("t6_req", 32'(mem_req), 32'd0);
        desvio = 1'b1; alvo = 8'd40;
        #1 check("t6_pc_hold", 32'(proximo_pc), 32'(pc));
        tick();
        desvio = 1'b0;
        check("t6_sticky", 32'(erro), 32'd1);
        check("t6_req_low", 32'(mem_req), 32'd0);
        rst_n = 1'b0;
        #1 check("t6_rst_clear", 32'(erro), 32'd0);
        rst_n = 1'b1;
`else
        // No answer: waits indefinitely, erro stays 0
        for (int i = 0; i < 20; i++) tick();
        check("t6_erro_tied", 32'(erro), 32'd0);
        check("t6_still_req", 32'(mem_req), 32'd1);
        check("t6_still_end", 32'(mem_end), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
